// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM peripheral.
// Also holds the duty compare rule used by the output stage.
package pwm_pkg;

    localparam int unsigned PWM_STEPS       = 256;
    localparam int unsigned PWM_CNT_W       = 8;
    localparam int unsigned CLK_DIV_DEFAULT = 13;
    localparam int unsigned PRESC_W         = 12;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    // Full scale means always high, so the last step is not lost to the strict compare.
    function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == '1) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler plus 8-bit step counter.
// Flags the last prescaler cycle of step 255 as the period wrap.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] cnt,
    output logic                 wrap
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0]   presc_q;
    logic [PWM_CNT_W-1:0] cnt_q;
    logic                 tick;

    assign tick = (presc_q == PRESC_MAX);
    assign wrap = tick && (cnt_q == '1);
    assign cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM peripheral: per-pin enable and PWM-mode select around one shared PWM signal.
// Duty is shadowed and only updated at the period wrap.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out
);

    logic [PWM_CNT_W-1:0] cnt;
    logic                 wrap;
    logic [PWM_CNT_W-1:0] duty_sh;
    logic                 pwm_sig;
    logic [15:0]          en_out;
    logic [15:0]          en_pwm;
    logic [15:0]          out_d;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .wrap  (wrap)
    );

    assign en_out  = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign pwm_sig = pwm_level(cnt, duty_sh);

    // Every PWM-mode pin takes the same pwm_sig, so all pulse edges line up.
    always_comb begin
        out_d = en_out & (~en_pwm | {16{pwm_sig}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_sh <= '0;
            out     <= '0;
        end else begin
            if (wrap) begin
                duty_sh <= pwm_duty_cycle;
            end
            out <= out_d;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral: timeline model compared every cycle,
// plus hand-computed pulse-width and level expectations.
module tb_pwm_peripheral;

    localparam int D = 13;
    localparam int P = 256 * D;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;

    pwm_peripheral #(
        .CLK_DIV (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model: k = clk edges since reset; time within the period gives the step,
    // and the duty used for a period is the input seen on the last cycle of the previous one.
    int          k = 0;
    int          shadow = 0;
    bit          model_valid = 1'b0;
    logic [15:0] exp_out = '0;
    int          hist [8];

    always @(posedge clk) begin
        int  step;
        bit  sig;
        logic [15:0] eo;
        logic [15:0] ep;
        if (!rst_n) begin
            exp_out     = '0;
            k           = 0;
            shadow      = 0;
            model_valid = 1'b1;
        end else begin
            step = (k % P) / D;
            sig  = (shadow == 255) || (step < shadow);
            eo   = {en_reg_out_15_8, en_reg_out_7_0};
            ep   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
            for (int i = 0; i < 16; i++) begin
                exp_out[i] = eo[i] && (!ep[i] || sig);
            end
            if (k % P == P - 1) shadow = int'(pwm_duty_cycle);
            k++;
        end
    end

    // Per-cycle compare, plus high-cycle histogram of out[0] per period.
    always @(negedge clk) begin
        if (model_valid) begin
            check("out_vs_model", 32'(out), 32'(exp_out));
            if (k == 0) begin
                for (int i = 0; i < 8; i++) hist[i] = 0;
            end else if ((k - 1) / P < 8) begin
                hist[(k - 1) / P] += int'(out[0]);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k != target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            check("wait_k_timeout", 32'(k), 32'(target));
        end
    endtask

    task automatic set_pins(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
        pwm_duty_cycle = duty;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = 0;
        rst_n = 1'b0;
        set_pins(16'h0000, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_out", 32'(out), 32'h0);

        // Static drive appears one clock after the enables change.
        rst_n = 1'b1;
        @(negedge clk);
        set_pins(16'h00FF, 16'h0000, 8'h00);
        @(negedge clk);
        check("static_1clk", 32'(out), 32'h00FF);
        repeat (20) @(negedge clk);
        check("static_hold", 32'(out), 32'h00FF);

        // 50% duty; first period after reset is all low.
        set_pins(16'h0001, 16'h0001, 8'h80);
        do_reset();
        wait_k(2 * P + 1);
        check("half_first_period_low", 32'(hist[0]), 32'd0);
        check("half_high_cycles", 32'(hist[1]), 32'd1664);
        check("half_low_cycles", 32'(P - hist[1]), 32'd1664);

        // Extremes.
        set_pins(16'h0001, 16'h0001, 8'h00);
        do_reset();
        wait_k(3 * P + 1);
        check("duty00_p1", 32'(hist[1]), 32'd0);
        check("duty00_p2", 32'(hist[2]), 32'd0);
        set_pins(16'h0001, 16'h0001, 8'hFF);
        do_reset();
        wait_k(3 * P + 1);
        check("dutyFF_p1", 32'(hist[1]), 32'd3328);
        check("dutyFF_p2", 32'(hist[2]), 32'd3328);

        // Mid-period change only lands at the next period.
        set_pins(16'h0001, 16'h0001, 8'h40);
        do_reset();
        wait_k(P + 100 * D);
        pwm_duty_cycle = 8'hC0;
        wait_k(3 * P + 1);
        check("mid_change_cur", 32'(hist[1]), 32'd832);
        check("mid_change_next", 32'(hist[2]), 32'd2496);

        // Change coincident with the wrap tick is captured for the next period.
        set_pins(16'h0001, 16'h0001, 8'h20);
        do_reset();
        wait_k(P - 1);
        pwm_duty_cycle = 8'h60;
        @(negedge clk);
        pwm_duty_cycle = 8'h20;
        wait_k(2 * P + 1);
        check("wrap_same_cycle", 32'(hist[1]), 32'd1248);

        // Reset mid-period.
        set_pins(16'h0001, 16'h0001, 8'h80);
        do_reset();
        wait_k(P + 150 * D);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_out", 32'(out), 32'h0);
        rst_n = 1'b1;
        wait_k(2 * P + 1);
        check("reset_mid_p0", 32'(hist[0]), 32'd0);
        check("reset_mid_p1", 32'(hist[1]), 32'd1664);

        // Mixed pins: even bits static high, odd bits pulse together.
        set_pins(16'hFFFF, 16'hAAAA, 8'h40);
        do_reset();
        wait_k(P + 10 * D);
        check("mixed_high_phase", 32'(out), 32'hFFFF);
        wait_k(P + 100 * D);
        check("mixed_low_phase", 32'(out), 32'h5555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
